// File: rtl/iq_demod_pkg.sv
// Shared definitions for the IQ demodulator filter scheduler.
// Contents:
//    sched_state_t : scheduler FSM states
//    CH_I / CH_Q   : channel encodings used on dp_chan / out_chan
//    NPH_DEFAULT   : default number of folded tap-pair phases
//    pick_grant    : round-robin channel choice between the two buffers
package iq_demod_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        TAP,
        DRAIN,
        DONE
    } sched_state_t;

    localparam logic CH_I = 1'b0;
    localparam logic CH_Q = 1'b1;

    localparam int NPH_DEFAULT = 5;

    // When both channels wait, the one that was not served last wins;
    // otherwise whichever channel is pending is taken.
    function automatic logic pick_grant(input logic pend_i,
                                        input logic pend_q,
                                        input logic last_grant);
        logic grant;
        if (pend_i && pend_q) begin
            grant = ~last_grant;
        end else if (pend_i) begin
            grant = CH_I;
        end else begin
            grant = CH_Q;
        end
        return grant;
    endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// Delays the accumulator strobes so they line up with products leaving the
// multiplier pipeline.
// Ports:
//    clk, reset     : clock and synchronous active-high reset
//    i_clr, i_en    : TAP-phase clear/enable strobes
//    o_clr, o_en    : the same strobes DEPTH cycles later
module ctrl_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_clr,
    output logic o_en
);

    logic [1:0] r_chain [DEPTH];

    // Plain shift chain of {clr, en}; reset empties it so an aborted job
    // cannot leak strobes into the accumulator afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_chain[i] <= 2'b00;
            end
        end else begin
            r_chain[0] <= {i_clr, i_en};
            for (int i = 1; i < DEPTH; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign {o_clr, o_en} = r_chain[DEPTH-1];

endmodule

// File: rtl/iq_filter_sched.sv
// Scheduler sharing one folded symmetric FIR datapath between I and Q.
// Ports:
//    clk, reset                : clock, synchronous active-high reset
//    en                        : permits new jobs to start
//    i_valid/i_data            : I sample strobe and value
//    q_valid/q_data            : Q sample strobe and value
//    dp_shift_en/dp_chan/dp_data : delay-line shift control to the datapath
//    dp_sel                    : tap-pair phase select
//    dp_acc_clr/dp_acc_en      : accumulator load/add strobes
//    dp_result                 : accumulator result from the datapath
//    out_valid/out_chan/out_data : tagged filtered result
//    ovf_i/ovf_q, ovf_clr      : sticky drop flags and their clear
//    busy                      : a job is in progress
module iq_filter_sched
    import iq_demod_pkg::*;
#(
    parameter int DW       = 5,
    parameter int NPH      = NPH_DEFAULT,
    parameter int PIPE_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 i_valid,
    input  logic signed [DW-1:0] i_data,
    input  logic                 q_valid,
    input  logic signed [DW-1:0] q_data,
    output logic                 dp_shift_en,
    output logic                 dp_chan,
    output logic signed [DW-1:0] dp_data,
    output logic [2:0]           dp_sel,
    output logic                 dp_acc_clr,
    output logic                 dp_acc_en,
    input  logic signed [DW-1:0] dp_result,
    output logic                 out_valid,
    output logic                 out_chan,
    output logic signed [DW-1:0] out_data,
    output logic                 ovf_i,
    output logic                 ovf_q,
    input  logic                 ovf_clr,
    output logic                 busy
);

    localparam int DCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    sched_state_t         r_state, w_state_next;
    logic [2:0]           r_ph;
    logic [DCW-1:0]       r_drain;
    logic                 r_grant;
    logic                 w_grant_next, w_start, w_can_start;
    logic                 w_tap_clr, w_tap_en;
    logic                 w_free_i, w_free_q;
    logic                 r_pend_i, r_pend_q, r_ovf_i, r_ovf_q;
    logic signed [DW-1:0] r_buf_i, r_buf_q, r_out_data;
    logic                 r_out_valid, r_out_chan;

    assign w_can_start = en && (r_pend_i || r_pend_q);
    assign w_free_i    = (r_state == SHIFT) && (r_grant == CH_I);
    assign w_free_q    = (r_state == SHIFT) && (r_grant == CH_Q);

    // State register plus the phase and drain counters. r_grant doubles as
    // the last-granted channel; resetting it to Q lets I win the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ph    <= '0;
            r_drain <= '0;
            r_grant <= CH_Q;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_grant <= w_grant_next;
                r_ph    <= '0;
            end else if (r_state == TAP && r_ph != 3'(NPH - 1)) begin
                r_ph <= r_ph + 3'd1;
            end
            r_drain <= (r_state == DRAIN) ? r_drain + DCW'(1) : '0;
        end
    end

    // Next-state and datapath control decode. dp_sel holds its last phase
    // through DRAIN/DONE so the control lines stay quiet while the pipe
    // empties; everything reads 0 in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_grant_next = pick_grant(r_pend_i, r_pend_q, r_grant);
        dp_shift_en  = 1'b0;
        dp_chan      = CH_I;
        dp_data      = '0;
        dp_sel       = '0;
        w_tap_clr    = 1'b0;
        w_tap_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_can_start) begin
                    w_state_next = SHIFT;
                    w_start      = 1'b1;
                end
            end
            SHIFT: begin
                dp_shift_en  = 1'b1;
                dp_chan      = r_grant;
                dp_data      = (r_grant == CH_Q) ? r_buf_q : r_buf_i;
                dp_sel       = r_ph;
                w_state_next = TAP;
            end
            TAP: begin
                dp_chan   = r_grant;
                dp_sel    = r_ph;
                w_tap_clr = (r_ph == 3'd0);
                w_tap_en  = (r_ph != 3'd0);
                if (r_ph == 3'(NPH - 1)) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                dp_chan = r_grant;
                dp_sel  = r_ph;
                if (r_drain == DCW'(PIPE_LAT - 1)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                dp_chan = r_grant;
                dp_sel  = r_ph;
                if (w_can_start) begin
                    w_state_next = SHIFT;
                    w_start      = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // One-deep input buffers. The SHIFT cycle frees the granted channel's
    // slot, so a strobe arriving in that same cycle is taken rather than
    // counted as a drop. A drop beats a simultaneous ovf_clr.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_i <= 1'b0;
            r_pend_q <= 1'b0;
            r_buf_i  <= '0;
            r_buf_q  <= '0;
            r_ovf_i  <= 1'b0;
            r_ovf_q  <= 1'b0;
        end else begin
            if (i_valid && (!r_pend_i || w_free_i)) begin
                r_buf_i  <= i_data;
                r_pend_i <= 1'b1;
            end else if (w_free_i) begin
                r_pend_i <= 1'b0;
            end
            if (q_valid && (!r_pend_q || w_free_q)) begin
                r_buf_q  <= q_data;
                r_pend_q <= 1'b1;
            end else if (w_free_q) begin
                r_pend_q <= 1'b0;
            end
            if (i_valid && r_pend_i && !w_free_i) begin
                r_ovf_i <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf_i <= 1'b0;
            end
            if (q_valid && r_pend_q && !w_free_q) begin
                r_ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf_q <= 1'b0;
            end
        end
    end

    // Result capture: the accumulator is complete during DONE, and the
    // registered copy is presented together with a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_chan  <= CH_I;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= (r_state == DONE);
            if (r_state == DONE) begin
                r_out_data <= dp_result;
                r_out_chan <= r_grant;
            end
        end
    end

    ctrl_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_ctrl_delay (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_tap_clr),
        .i_en  (w_tap_en),
        .o_clr (dp_acc_clr),
        .o_en  (dp_acc_en)
    );

    assign out_valid = r_out_valid;
    assign out_chan  = r_out_chan;
    assign out_data  = r_out_data;
    assign ovf_i     = r_ovf_i;
    assign ovf_q     = r_ovf_q;
    assign busy      = (r_state != IDLE);

endmodule
